// File: rtl/scs8hd_latch_wr_pkg.sv
// -----------------------------------------------------------------------------
// scs8hd_latch_wr_pkg
// Shared types and sizing helpers for the latch write sequencer.
//
// Contents:
//   wr_state_e  - sequencer state encoding (IDLE, SETUP, PULSE, HOLD)
//   clog2_min1  - $clog2 clamped to a minimum of 1, so that counter and
//                 address vectors never collapse to zero width
//   max3        - largest of three integers, used to size the shared
//                 phase counter
// No ports (package).
// -----------------------------------------------------------------------------
package scs8hd_latch_wr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_PULSE = 2'd2,
    ST_HOLD  = 2'd3
  } wr_state_e;

  function automatic int clog2_min1(input int value);
    int w;
    w = $clog2(value);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/scs8hd_latch_wr_dec.sv
// -----------------------------------------------------------------------------
// scs8hd_latch_wr_dec
// Registered one-hot GATE decoder with enable, broadcast and range check.
// The GATE outputs come straight from flops so the latch enables cannot
// glitch while the address or enable logic settles.
//
// Ports:
//   clk_i       in   clock, rising edge
//   rst_ni      in   asynchronous active-low reset (clears all GATE bits)
//   en_i        in   GATE pattern for the next cycle is enabled (next state
//                    is PULSE)
//   bcast_i     in   drive every GATE bit instead of a single word
//   addr_i      in   AW-bit word address, already muxed to the value that
//                    will be in effect next cycle
//   in_range_o  out  combinational: addr_i < NUM_WORDS
//   gate_o      out  NUM_WORDS registered latch enables
// -----------------------------------------------------------------------------
module scs8hd_latch_wr_dec
  import scs8hd_latch_wr_pkg::*;
#(
  parameter int NUM_WORDS = 8,
  parameter int AW        = clog2_min1(NUM_WORDS)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 en_i,
  input  logic                 bcast_i,
  input  logic [AW-1:0]        addr_i,
  output logic                 in_range_o,
  output logic [NUM_WORDS-1:0] gate_o
);

  logic [NUM_WORDS-1:0] gate_d;
  logic [NUM_WORDS-1:0] gate_q;

  assign in_range_o = (32'(addr_i) < 32'(NUM_WORDS));

  // A word only matches its own index, so an out-of-range address simply
  // matches nothing and the whole pattern stays low.
  generate
    for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : g_word
      assign gate_d[gi] = en_i & (bcast_i | (32'(addr_i) == 32'(gi)));
    end
  endgenerate

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      gate_q <= '0;
    end else begin
      gate_q <= gate_d;
    end
  end

  assign gate_o = gate_q;

endmodule

// File: rtl/scs8hd_latch_wr_seq.sv
// -----------------------------------------------------------------------------
// scs8hd_latch_wr_seq
// Write sequencer for arrays of positive-level transparent latches. A write
// accepted over REQ_VALID/REQ_READY puts its data on D, waits SETUP_CYC
// cycles, raises exactly one GATE line for PULSE_CYC cycles, then holds D
// for HOLD_CYC cycles before returning ready.
//
// Optional feature macro: SCS8HD_LATCH_WR_BCAST_EN
//   When defined, the REQ_BCAST input exists; a broadcast write pulses all
//   GATE lines together, ignores REQ_ADDR and never raises ERR.
//
// Ports:
//   CLK        in   clock, rising edge
//   RESET_B    in   asynchronous active-low reset
//   REQ_VALID  in   write request valid
//   REQ_READY  out  sequencer idle, request will be accepted
//   REQ_ADDR   in   target word (AW bits)
//   REQ_DATA   in   write data (WIDTH bits)
//   REQ_BCAST  in   broadcast write (only with SCS8HD_LATCH_WR_BCAST_EN)
//   D          out  registered latch data bus
//   GATE       out  one-hot latch enables, flop-driven
//   BUSY       out  write sequence in progress
//   ERR        out  one-cycle pulse after accepting an out-of-range address
// -----------------------------------------------------------------------------
module scs8hd_latch_wr_seq
  import scs8hd_latch_wr_pkg::*;
#(
  parameter  int NUM_WORDS = 8,
  parameter  int WIDTH     = 8,
  parameter  int SETUP_CYC = 1,
  parameter  int PULSE_CYC = 2,
  parameter  int HOLD_CYC  = 1,
  localparam int AW        = clog2_min1(NUM_WORDS)
) (
  input  logic                 CLK,
  input  logic                 RESET_B,
  input  logic                 REQ_VALID,
  output logic                 REQ_READY,
  input  logic [AW-1:0]        REQ_ADDR,
  input  logic [WIDTH-1:0]     REQ_DATA,
`ifdef SCS8HD_LATCH_WR_BCAST_EN
  input  logic                 REQ_BCAST,
`endif
  output logic [WIDTH-1:0]     D,
  output logic [NUM_WORDS-1:0] GATE,
  output logic                 BUSY,
  output logic                 ERR
);

  // One down-counter is shared by every phase, so it is sized for the
  // longest of them.
  localparam int CW = clog2_min1(max3(SETUP_CYC, PULSE_CYC, HOLD_CYC) + 1);

  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYC);
  localparam logic [CW-1:0] PULSE_LD = CW'(PULSE_CYC);
  localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_CYC);

  // Zero-length SETUP/HOLD phases are skipped entirely.
  localparam wr_state_e FIRST_ST   = (SETUP_CYC > 0) ? ST_SETUP : ST_PULSE;
  localparam wr_state_e PULSE_EXIT = (HOLD_CYC > 0)  ? ST_HOLD  : ST_IDLE;

  wr_state_e        state_q;
  wr_state_e        state_d;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_d;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;
  logic [AW-1:0]    addr_q;
  logic [AW-1:0]    addr_d;
  logic             bcast_q;
  logic             bcast_d;
  logic             err_q;
  logic             err_d;

  logic             ready;
  logic             accept;
  logic             bcast_in;
  logic             addr_in_range;
  logic             gate_en;

`ifdef SCS8HD_LATCH_WR_BCAST_EN
  assign bcast_in = REQ_BCAST;
`else
  assign bcast_in = 1'b0;
`endif

  assign accept = REQ_VALID & ready;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RESET_B) begin
    if (!RESET_B) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept)            state_d = FIRST_ST;
      ST_SETUP: if (cnt_q == CNT_ONE)  state_d = ST_PULSE;
      ST_PULSE: if (cnt_q == CNT_ONE)  state_d = PULSE_EXIT;
      ST_HOLD:  if (cnt_q == CNT_ONE)  state_d = ST_IDLE;
      default:                         state_d = ST_IDLE;
    endcase
  end

  // Counter is reloaded on every state change and otherwise counts down,
  // stopping at 1 (the exit condition) so it can never wrap.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      case (state_d)
        ST_SETUP: cnt_d = SETUP_LD;
        ST_PULSE: cnt_d = PULSE_LD;
        ST_HOLD:  cnt_d = HOLD_LD;
        default:  cnt_d = '0;
      endcase
    end else if (cnt_q > CNT_ONE) begin
      cnt_d = cnt_q - CNT_ONE;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    ready = (state_q == ST_IDLE);
    BUSY  = (state_q != ST_IDLE);
  end

  assign REQ_READY = ready;

  // ---------------------------------------------------------------------------
  // Request capture: data, address and broadcast flag change only on accept,
  // which keeps D stable through SETUP, PULSE and HOLD.
  // ---------------------------------------------------------------------------
  always_comb begin
    data_d  = data_q;
    addr_d  = addr_q;
    bcast_d = bcast_q;
    if (accept) begin
      data_d  = REQ_DATA;
      addr_d  = REQ_ADDR;
      bcast_d = bcast_in;
    end
  end

  // addr_in_range is evaluated on addr_d, which equals REQ_ADDR during accept.
  assign err_d = accept & ~bcast_in & ~addr_in_range;

  always_ff @(posedge CLK or negedge RESET_B) begin
    if (!RESET_B) begin
      data_q  <= '0;
      addr_q  <= '0;
      bcast_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      addr_q  <= addr_d;
      bcast_q <= bcast_d;
      err_q   <= err_d;
    end
  end

  assign D   = data_q;
  assign ERR = err_q;

  // ---------------------------------------------------------------------------
  // GATE generation. The decoder registers its output, so it is fed with the
  // next-cycle view (state_d, addr_d, bcast_d); GATE is then high exactly in
  // the cycles where state_q is PULSE.
  // ---------------------------------------------------------------------------
  assign gate_en = (state_d == ST_PULSE);

  scs8hd_latch_wr_dec #(
    .NUM_WORDS (NUM_WORDS),
    .AW        (AW)
  ) u_dec (
    .clk_i      (CLK),
    .rst_ni     (RESET_B),
    .en_i       (gate_en),
    .bcast_i    (bcast_d),
    .addr_i     (addr_d),
    .in_range_o (addr_in_range),
    .gate_o     (GATE)
  );

endmodule

// File: tb/tb_scs8hd_latch_wr_seq.sv
module tb_scs8hd_latch_wr_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // Instance A: all defaults
  logic       a_valid, a_ready, a_busy, a_err;
  logic [2:0] a_addr;
  logic [7:0] a_data, a_d, a_gate;
`ifdef SCS8HD_LATCH_WR_BCAST_EN
  logic       a_bcast, b_bcast, c_bcast;
`endif

  // Instance B: NUM_WORDS=6, default timing (scoreboarded)
  logic       b_valid, b_ready, b_busy, b_err;
  logic [2:0] b_addr;
  logic [7:0] b_data, b_d;
  logic [5:0] b_gate;

  // Instance C: SETUP=0, PULSE=1, HOLD=0
  logic       c_valid, c_ready, c_busy, c_err;
  logic [2:0] c_addr;
  logic [7:0] c_data, c_d, c_gate;

  scs8hd_latch_wr_seq u_a (
    .CLK(clk), .RESET_B(rst_n), .REQ_VALID(a_valid), .REQ_READY(a_ready),
    .REQ_ADDR(a_addr), .REQ_DATA(a_data),
`ifdef SCS8HD_LATCH_WR_BCAST_EN
    .REQ_BCAST(a_bcast),
`endif
    .D(a_d), .GATE(a_gate), .BUSY(a_busy), .ERR(a_err)
  );

  scs8hd_latch_wr_seq #(.NUM_WORDS(6)) u_b (
    .CLK(clk), .RESET_B(rst_n), .REQ_VALID(b_valid), .REQ_READY(b_ready),
    .REQ_ADDR(b_addr), .REQ_DATA(b_data),
`ifdef SCS8HD_LATCH_WR_BCAST_EN
    .REQ_BCAST(b_bcast),
`endif
    .D(b_d), .GATE(b_gate), .BUSY(b_busy), .ERR(b_err)
  );

  scs8hd_latch_wr_seq #(.SETUP_CYC(0), .PULSE_CYC(1), .HOLD_CYC(0)) u_c (
    .CLK(clk), .RESET_B(rst_n), .REQ_VALID(c_valid), .REQ_READY(c_ready),
    .REQ_ADDR(c_addr), .REQ_DATA(c_data),
`ifdef SCS8HD_LATCH_WR_BCAST_EN
    .REQ_BCAST(c_bcast),
`endif
    .D(c_d), .GATE(c_gate), .BUSY(c_busy), .ERR(c_err)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  typedef struct {
    logic [2:0] addr;
    logic [7:0] data;
    logic [5:0] gate;
    logic       err;
  } vec_t;

  typedef struct {
    logic [7:0] data;
    logic [5:0] gate;
    logic [3:0] err_bits;
    int         pulse_len;
  } exp_t;

  exp_t sb_q[$];

  // Scoreboard monitor for instance B: one record per busy period.
  initial begin
    bit         in_txn;
    int         blen, plen;
    logic [5:0] gacc;
    logic [3:0] eb;
    logic [7:0] dfirst;
    bit         dchg, multi;
    exp_t       e;
    in_txn = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_txn = 0;
      end else if (b_busy) begin
        if (!in_txn) begin
          in_txn = 1; blen = 0; plen = 0; gacc = '0; eb = '0;
          dfirst = b_d; dchg = 0; multi = 0;
        end
        if (blen < 4) eb[blen] = b_err;
        if (b_gate != 6'd0) plen++;
        if ($countones(b_gate) > 1) multi = 1;
        if (b_d !== dfirst) dchg = 1;
        gacc = gacc | b_gate;
        blen++;
      end else if (in_txn) begin
        in_txn = 0;
        if (sb_q.size() == 0) begin
          n_checks++;
          $display("FAIL sb_underflow: got a completed write, expected none");
        end else begin
          e = sb_q.pop_front();
          $display("txn B data=%0h gate=%0h err_bits=%0h busy=%0d pulse=%0d", dfirst, gacc, eb, blen, plen);
          chk("b_data", 32'(dfirst), 32'(e.data));
          chk("b_gate", 32'(gacc), 32'(e.gate));
          chk("b_err_bits", 32'(eb), 32'(e.err_bits));
          chk("b_pulse_len", plen, e.pulse_len);
          chk("b_busy_len", blen, 4);
          chk("b_onehot_viol", 32'(multi), 0);
          chk("b_d_stable", 32'(dchg), 0);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs[8];
    logic [7:0] exp_gate_a[11];
    int waited;
    exp_t e;

    vecs[0] = '{3'd0, 8'h11, 6'b000001, 1'b0};
    vecs[1] = '{3'd5, 8'h22, 6'b100000, 1'b0};
    vecs[2] = '{3'd6, 8'h33, 6'b000000, 1'b1};
    vecs[3] = '{3'd3, 8'h44, 6'b001000, 1'b0};
    vecs[4] = '{3'd7, 8'h55, 6'b000000, 1'b1};
    vecs[5] = '{3'd1, 8'h66, 6'b000010, 1'b0};
    vecs[6] = '{3'd2, 8'h77, 6'b000100, 1'b0};
    vecs[7] = '{3'd4, 8'h88, 6'b010000, 1'b0};

    rst_n = 1'b0;
    a_valid = 0; a_addr = 0; a_data = 0;
    b_valid = 0; b_addr = 0; b_data = 0;
    c_valid = 0; c_addr = 0; c_data = 0;
`ifdef SCS8HD_LATCH_WR_BCAST_EN
    a_bcast = 0; b_bcast = 0; c_bcast = 0;
`endif
    repeat (3) cyc();

    // Reset state
    chk("rst_ready", 32'(a_ready), 1);
    chk("rst_d", 32'(a_d), 0);
    chk("rst_gate", 32'(a_gate), 0);
    chk("rst_busy", 32'(a_busy), 0);
    chk("rst_err", 32'(a_err), 0);
    chk("rst_b_ready", 32'(b_ready), 1);
    chk("rst_c_gate", 32'(c_gate), 0);
    $display("txn reset checked");

    // Single write right after release: ADDR=3, DATA=A5
    rst_n = 1'b1;
    chk("sw_ready_c0", 32'(a_ready), 1);
    a_valid = 1; a_addr = 3'd3; a_data = 8'hA5;
    cyc();                                     // cycle 1
    a_valid = 0;
    chk("sw_d_c1", 32'(a_d), 32'h A5);
    chk("sw_gate_c1", 32'(a_gate), 0);
    chk("sw_busy_c1", 32'(a_busy), 1);
    chk("sw_ready_c1", 32'(a_ready), 0);
    cyc();                                     // cycle 2
    chk("sw_gate_c2", 32'(a_gate), 32'h08);
    cyc();                                     // cycle 3
    chk("sw_gate_c3", 32'(a_gate), 32'h08);
    cyc();                                     // cycle 4
    chk("sw_gate_c4", 32'(a_gate), 0);
    chk("sw_d_c4", 32'(a_d), 32'hA5);
    chk("sw_ready_c4", 32'(a_ready), 0);
    cyc();                                     // cycle 5
    chk("sw_ready_c5", 32'(a_ready), 1);
    chk("sw_busy_c5", 32'(a_busy), 0);
    $display("txn A single write addr=3 data=a5 done");

    // Back-to-back on A: VALID held, second request waits while busy
    exp_gate_a = '{8'h00, 8'h00, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h80, 8'h80, 8'h00, 8'h00};
    a_valid = 1; a_addr = 3'd0; a_data = 8'h11;
    for (int k = 0; k < 11; k++) begin
      chk($sformatf("b2b_gate_c%0d", k), 32'(a_gate), 32'(exp_gate_a[k]));
      if (k == 1) begin
        chk("b2b_d_c1", 32'(a_d), 32'h11);
        a_addr = 3'd7; a_data = 8'h22;
      end
      if (k == 4) chk("b2b_d_c4", 32'(a_d), 32'h11);
      if (k == 5) chk("b2b_ready_c5", 32'(a_ready), 1);
      if (k == 6) begin
        chk("b2b_d_c6", 32'(a_d), 32'h22);
        a_valid = 0;
      end
      if (k == 10) chk("b2b_ready_c10", 32'(a_ready), 1);
      cyc();
    end
    $display("txn A back-to-back 0/11 then 7/22 done");

    // Zero setup/hold on C
    chk("z_ready_c0", 32'(c_ready), 1);
    c_valid = 1; c_addr = 3'd1; c_data = 8'h77;
    cyc();
    c_valid = 0;
    chk("z_gate_c1", 32'(c_gate), 32'h02);
    chk("z_busy_c1", 32'(c_busy), 1);
    chk("z_d_c1", 32'(c_d), 32'h77);
    cyc();
    chk("z_gate_c2", 32'(c_gate), 0);
    chk("z_ready_c2", 32'(c_ready), 1);
    $display("txn C zero-setup addr=1 data=77 done");

    // Table-driven stream on B (NUM_WORDS=6), requests held across busy
    for (int i = 0; i < 8; i++) begin
      b_valid = 1; b_addr = vecs[i].addr; b_data = vecs[i].data;
      waited = 0;
      while (!b_ready && waited < 20) begin
        cyc();
        waited++;
      end
      if (!b_ready) begin
        chk($sformatf("b_ready_timeout_%0d", i), 32'(b_ready), 1);
      end else begin
        e.data      = vecs[i].data;
        e.gate      = vecs[i].gate;
        e.err_bits  = vecs[i].err ? 4'b0001 : 4'b0000;
        e.pulse_len = (vecs[i].gate != 6'd0) ? 2 : 0;
        sb_q.push_back(e);
        if (i > 0) chk($sformatf("b_gap_%0d", i), waited, 4);
      end
      cyc();
    end
    b_valid = 0;
    waited = 0;
    while (sb_q.size() != 0 && waited < 20) begin
      cyc();
      waited++;
    end
    chk("b_sb_drain", sb_q.size(), 0);

`ifdef SCS8HD_LATCH_WR_BCAST_EN
    // Broadcast write on A
    cyc();
    a_valid = 1; a_bcast = 1; a_addr = 3'd3; a_data = 8'h3C;
    cyc();
    a_valid = 0; a_bcast = 0;
    chk("bc_err_c1", 32'(a_err), 0);
    chk("bc_d_c1", 32'(a_d), 32'h3C);
    cyc();
    chk("bc_gate_c2", 32'(a_gate), 32'hFF);
    cyc();
    chk("bc_gate_c3", 32'(a_gate), 32'hFF);
    cyc();
    chk("bc_gate_c4", 32'(a_gate), 0);
    cyc();
    chk("bc_ready_c5", 32'(a_ready), 1);
    $display("txn A broadcast data=3c done");
`endif

    // Reset mid-pulse on A
    cyc();
    a_valid = 1; a_addr = 3'd2; a_data = 8'h5A;
    cyc();
    a_valid = 0;
    cyc();
    chk("rp_gate_c2", 32'(a_gate), 32'h04);
    #2 rst_n = 1'b0;
    #1;
    chk("rp_gate_async", 32'(a_gate), 0);
    chk("rp_d_async", 32'(a_d), 0);
    chk("rp_busy_async", 32'(a_busy), 0);
    chk("rp_ready_async", 32'(a_ready), 1);
    cyc();
    rst_n = 1'b1;
    chk("rp_ready_rel", 32'(a_ready), 1);
    a_valid = 1; a_addr = 3'd2; a_data = 8'hC3;
    cyc();
    a_valid = 0;
    chk("rp2_d_c1", 32'(a_d), 32'hC3);
    cyc();
    chk("rp2_gate_c2", 32'(a_gate), 32'h04);
    cyc();
    chk("rp2_gate_c3", 32'(a_gate), 32'h04);
    cyc();
    chk("rp2_gate_c4", 32'(a_gate), 0);
    cyc();
    chk("rp2_ready_c5", 32'(a_ready), 1);
    $display("txn A reset mid-pulse then rewrite addr=2 data=c3 done");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
